// File: rtl/note_timer_mc_if.sv
// ---------------------------------------------------------------------------
// note_timer_mc_if
// Bundles the beat/hold/load/duration inputs and the playing/note_done/
// any_done/remaining outputs of the multi-channel note timer.
//   master : sequencer side (drives beat, hold, load, duration)
//   slave  : timer side (drives playing, note_done, any_done, remaining)
// Parameters N_CH and DUR_W must match those of the attached note_timer_mc.
// ---------------------------------------------------------------------------
interface note_timer_mc_if #(
    parameter int N_CH  = 4,
    parameter int DUR_W = 6
);
    logic                    beat;
    logic                    hold;
    logic [N_CH-1:0]         load;
    logic [N_CH*DUR_W-1:0]   duration;
    logic [N_CH-1:0]         playing;
    logic [N_CH-1:0]         note_done;
    logic                    any_done;
    logic [N_CH*DUR_W-1:0]   remaining;

    modport master (
        output beat, hold, load, duration,
        input  playing, note_done, any_done, remaining
    );

    modport slave (
        input  beat, hold, load, duration,
        output playing, note_done, any_done, remaining
    );
endinterface

// File: rtl/note_timer_mc.sv
// ---------------------------------------------------------------------------
// note_timer_mc
// Multi-channel note-duration timer. Each channel loads a note length in
// beats, counts it down on the shared beat tick, pulses note_done for one
// cycle when the note ends and then idles until the next load.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : note_timer_mc_if.slave
//              beat, hold, load[N_CH], duration[N_CH*DUR_W] (inputs)
//              playing[N_CH], note_done[N_CH], any_done,
//              remaining[N_CH*DUR_W]                       (outputs)
//
// Optional feature macro: NOTE_GAP_EN
//   defined   : notes end with GAP_TICKS silent beats (GAP state) before
//               note_done
//   undefined : PLAY goes straight to DONE; GAP_TICKS is ignored
// ---------------------------------------------------------------------------
module note_timer_mc #(
    parameter int N_CH      = 4,
    parameter int DUR_W     = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    note_timer_mc_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Elaboration-time guard on parameter ranges.
    if (N_CH < 1 || N_CH > 8 || GAP_TICKS < 0 || GAP_TICKS > 15) begin : g_param_err
        $error("note_timer_mc: N_CH must be 1..8 and GAP_TICKS 0..15");
    end

    logic                  tick;
    logic [N_CH-1:0]       playing_w;
    logic [N_CH-1:0]       done_w;
    logic [N_CH*DUR_W-1:0] rem_w;

    // A beat only counts while hold is low.
    assign tick = bus.beat & ~bus.hold;

    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
        state_t            state_q, state_d;
        logic [DUR_W-1:0]  cnt_q, cnt_d;
        logic [DUR_W-1:0]  dur;
`ifdef NOTE_GAP_EN
        logic [3:0]        gap_q, gap_d;
`endif

        assign dur = bus.duration[gi*DUR_W +: DUR_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
`ifdef NOTE_GAP_EN
                gap_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
`ifdef NOTE_GAP_EN
                gap_q   <= gap_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
`ifdef NOTE_GAP_EN
            gap_d   = gap_q;
`endif
            if (bus.load[gi]) begin
                // Load wins in every state, including DONE and mid-note.
                if (dur != '0) begin
                    state_d = S_PLAY;
                    cnt_d   = dur;
                end else begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_IDLE;
                    S_PLAY: begin
                        if (tick) begin
                            if (cnt_q == DUR_W'(1)) begin
                                cnt_d = '0;
`ifdef NOTE_GAP_EN
                                if (GAP_TICKS > 0) begin
                                    state_d = S_GAP;
                                    gap_d   = 4'(GAP_TICKS);
                                end else begin
                                    state_d = S_DONE;
                                end
`else
                                state_d = S_DONE;
`endif
                            end else begin
                                // Only reached with cnt_q >= 2, so no wrap.
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                    end
`ifdef NOTE_GAP_EN
                    S_GAP: begin
                        if (tick) begin
                            if (gap_q == 4'd1) begin
                                state_d = S_DONE;
                                gap_d   = '0;
                            end else begin
                                gap_d = gap_q - 1'b1;
                            end
                        end
                    end
`endif
                    S_DONE: state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end

        assign playing_w[gi]              = (state_q == S_PLAY);
        assign done_w[gi]                 = (state_q == S_DONE);
        assign rem_w[gi*DUR_W +: DUR_W]   = (state_q == S_PLAY) ? cnt_q : '0;
    end

    assign bus.playing   = playing_w;
    assign bus.note_done = done_w;
    assign bus.any_done  = |done_w;
    assign bus.remaining = rem_w;

endmodule

// File: tb/tb_note_timer_mc.sv
module tb_note_timer_mc;
    localparam int N_CH  = 4;
    localparam int DUR_W = 6;
    localparam int RW    = N_CH * DUR_W;

    logic clk;
    logic rst_n;

    note_timer_mc_if #(.N_CH(N_CH), .DUR_W(DUR_W)) bus ();

    note_timer_mc #(.N_CH(N_CH), .DUR_W(DUR_W), .GAP_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                pre;      // quiet cycles (hold kept at row value) before the row
        logic [N_CH-1:0]   ld;
        logic [RW-1:0]     dur;
        logic              bt;
        logic              hd;
        logic [N_CH-1:0]   ep;       // expected playing
        logic [N_CH-1:0]   ed;       // expected note_done
        logic [RW-1:0]     er;       // expected remaining
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [RW-1:0] pk(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic add(input int pre, input logic [N_CH-1:0] ld, input logic [RW-1:0] dur,
                       input logic bt, input logic hd, input logic [N_CH-1:0] ep,
                       input logic [N_CH-1:0] ed, input logic [RW-1:0] er);
        vec_t v;
        v.pre = pre; v.ld = ld; v.dur = dur; v.bt = bt; v.hd = hd;
        v.ep = ep; v.ed = ed; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [N_CH-1:0] ep,
                           input logic [N_CH-1:0] ed, input logic [RW-1:0] er);
        chk({tag, " playing"},   32'(bus.playing),   32'(ep));
        chk({tag, " note_done"}, 32'(bus.note_done), 32'(ed));
        chk({tag, " any_done"},  32'(bus.any_done),  32'(|ed));
        chk({tag, " remaining"}, 32'(bus.remaining), 32'(er));
        $display("%s: playing=%b note_done=%b any_done=%b remaining=%h", tag,
                 bus.playing, bus.note_done, bus.any_done, bus.remaining);
    endtask

    task automatic quiet();
        bus.load = '0; bus.duration = '0; bus.beat = 1'b0;
    endtask

    // Drive one cycle of inputs, sample just after the edge.
    task automatic step(input logic [N_CH-1:0] ld, input logic [RW-1:0] dur,
                        input logic bt, input logic hd);
        bus.load = ld; bus.duration = dur; bus.beat = bt; bus.hold = hd;
        @(posedge clk); #1;
        quiet();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.beat = 1'b0; bus.hold = 1'b0; bus.load = '0; bus.duration = '0;

`ifndef NOTE_GAP_EN
        // ch0 d=3, beat every 4 cycles
        add(0, 4'b0001, pk(3,0,0,0), 0, 0, 4'b0001, 4'b0000, pk(3,0,0,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0001, 4'b0000, pk(2,0,0,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0001, 4'b0000, pk(1,0,0,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0000, 4'b0001, '0);
        add(0, 4'b0000, '0,          0, 0, 4'b0000, 4'b0000, '0);
        // ch1 d=0
        add(0, 4'b0010, '0,          0, 0, 4'b0000, 4'b0010, '0);
        add(0, 4'b0000, '0,          0, 0, 4'b0000, 4'b0000, '0);
        // ch2 d=5 with hold after 2 beats
        add(0, 4'b0100, pk(0,0,5,0), 0, 0, 4'b0100, 4'b0000, pk(0,0,5,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0100, 4'b0000, pk(0,0,4,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0100, 4'b0000, pk(0,0,3,0));
        for (int i = 0; i < 10; i++)
            add(3, 4'b0000, '0,      1, 1, 4'b0100, 4'b0000, pk(0,0,3,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0100, 4'b0000, pk(0,0,2,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0100, 4'b0000, pk(0,0,1,0));
        add(3, 4'b0000, '0,          1, 0, 4'b0000, 4'b0100, '0);
        add(0, 4'b0000, '0,          0, 0, 4'b0000, 4'b0000, '0);
        // ch3 retrigger
        add(0, 4'b1000, pk(0,0,0,4), 0, 0, 4'b1000, 4'b0000, pk(0,0,0,4));
        add(3, 4'b0000, '0,          1, 0, 4'b1000, 4'b0000, pk(0,0,0,3));
        add(0, 4'b1000, pk(0,0,0,2), 0, 0, 4'b1000, 4'b0000, pk(0,0,0,2));
        add(3, 4'b0000, '0,          1, 0, 4'b1000, 4'b0000, pk(0,0,0,1));
        add(3, 4'b0000, '0,          1, 0, 4'b0000, 4'b1000, '0);
        add(0, 4'b0000, '0,          0, 0, 4'b0000, 4'b0000, '0);
        // all channels together
        add(0, 4'b1111, pk(2,2,2,2), 0, 0, 4'b1111, 4'b0000, pk(2,2,2,2));
        add(0, 4'b0000, '0,          1, 0, 4'b1111, 4'b0000, pk(1,1,1,1));
        add(0, 4'b0000, '0,          1, 0, 4'b0000, 4'b1111, '0);
        add(0, 4'b0000, '0,          0, 0, 4'b0000, 4'b0000, '0);
        // load during DONE, load beats a simultaneous beat, hold behaviour
        add(0, 4'b0001, pk(1,0,0,0), 0, 0, 4'b0001, 4'b0000, pk(1,0,0,0));
        add(0, 4'b0000, '0,          1, 0, 4'b0000, 4'b0001, '0);
        add(0, 4'b0001, pk(2,0,0,0), 0, 0, 4'b0001, 4'b0000, pk(2,0,0,0));
        add(0, 4'b0001, pk(5,0,0,0), 1, 0, 4'b0001, 4'b0000, pk(5,0,0,0));
        add(0, 4'b0010, '0,          1, 1, 4'b0001, 4'b0010, pk(5,0,0,0));
        add(0, 4'b0000, '0,          1, 1, 4'b0001, 4'b0000, pk(5,0,0,0));
        add(0, 4'b0000, '0,          1, 0, 4'b0001, 4'b0000, pk(4,0,0,0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", '0, '0, '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_out("after_reset", '0, '0, '0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].pre; k++) begin
                bus.hold = vecs[i].hd;
                @(posedge clk); #1;
            end
            step(vecs[i].ld, vecs[i].dur, vecs[i].bt, vecs[i].hd);
            chk_out($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ed, vecs[i].er);
        end
        bus.hold = 1'b0;

        // Asynchronous reset in the middle of notes
        step(4'b1111, pk(2,2,2,2), 0, 0);
        chk_out("pre_rst_load", 4'b1111, '0, pk(2,2,2,2));
        #3 rst_n = 1'b0;
        #1 chk_out("async_rst", '0, '0, '0);
        @(posedge clk); #1;
        chk_out("rst_held", '0, '0, '0);
        #2 rst_n = 1'b1;
        step('0, '0, 1, 0);
        chk_out("post_rst_beat", '0, '0, '0);

`ifdef NOTE_GAP_EN
        // GAP_TICKS=2, d=3
        step(4'b0001, pk(3,0,0,0), 0, 0);
        chk_out("gap_load", 4'b0001, '0, pk(3,0,0,0));
        step('0, '0, 1, 0);
        chk_out("gap_b1", 4'b0001, '0, pk(2,0,0,0));
        step('0, '0, 1, 0);
        chk_out("gap_b2", 4'b0001, '0, pk(1,0,0,0));
        step('0, '0, 1, 0);
        chk_out("gap_b3", '0, '0, '0);
        step('0, '0, 1, 0);
        chk_out("gap_g1", '0, '0, '0);
        step('0, '0, 1, 0);
        chk_out("gap_g2", '0, 4'b0001, '0);
        step('0, '0, 0, 0);
        chk_out("gap_idle", '0, '0, '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
